// File: rtl/keypad_display_ctrl.sv
// Matrix keypad scanner with press/release debounce FSM feeding an N-digit,
// time-multiplexed active-low seven-segment display. Optional: KEYPAD_BLANK_EN.
module keypad_display_ctrl #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int NUM_DIGITS      = 2,
    parameter int ROW_DWELL       = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MUX_DIV         = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_COLS-1:0]   col,
    output logic [NUM_ROWS-1:0]   r_sel,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int DW_W  = $clog2(ROW_DWELL);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [1:0] ST_SCAN      = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_DEB_REL   = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef KEYPAD_BLANK_EN
    localparam logic [6:0] SEG_RESET = 7'b1111111;
`else
    localparam logic [6:0] SEG_RESET = 7'b1000000;
`endif

    function automatic logic [6:0] hex7_f(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // The 4x4 board uses a phone-style legend; other sizes use a linear index.
    function automatic logic [3:0] key_code_f(input logic [ROW_W-1:0] r,
                                              input logic [COL_W-1:0] c);
        logic [3:0] lin4;
        logic [3:0] code;
        lin4 = 4'(int'(r) * NUM_COLS + int'(c));
        if (NUM_ROWS == 4 && NUM_COLS == 4) begin
            case (lin4)
                4'd0:    code = 4'h1;
                4'd1:    code = 4'h2;
                4'd2:    code = 4'h3;
                4'd3:    code = 4'hA;
                4'd4:    code = 4'h4;
                4'd5:    code = 4'h5;
                4'd6:    code = 4'h6;
                4'd7:    code = 4'hB;
                4'd8:    code = 4'h7;
                4'd9:    code = 4'h8;
                4'd10:   code = 4'h9;
                4'd11:   code = 4'hC;
                4'd12:   code = 4'hE;
                4'd13:   code = 4'h0;
                4'd14:   code = 4'hF;
                4'd15:   code = 4'hD;
                default: code = 4'h0;
            endcase
        end else begin
            code = lin4;
        end
        return code;
    endfunction

    function automatic logic [ROW_W-1:0] next_row_f(input logic [ROW_W-1:0] r);
        return (r == ROW_W'(NUM_ROWS - 1)) ? ROW_W'(0) : r + ROW_W'(1);
    endfunction

    logic [NUM_COLS-1:0]   col_meta_q;
    logic [NUM_COLS-1:0]   col_s_q;
    logic [1:0]            state_q,     state_d;
    logic [ROW_W-1:0]      row_q,       row_d;
    logic [DW_W-1:0]       dwell_q,     dwell_d;
    logic [ROW_W-1:0]      lat_row_q,   lat_row_d;
    logic [COL_W-1:0]      lat_col_q,   lat_col_d;
    logic [DEB_W-1:0]      deb_cnt_q,   deb_cnt_d;
    logic                  key_valid_q, key_valid_d;
    logic [3:0]            key_code_q,  key_code_d;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [3:0]            digit_d [NUM_DIGITS];
`ifdef KEYPAD_BLANK_EN
    logic [NUM_DIGITS-1:0] valid_q,     valid_d;
`endif
    logic [MUX_DIV-1:0]    mux_cnt_q,   mux_cnt_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [NUM_ROWS-1:0]   r_sel_q,     r_sel_d;
    logic [6:0]            seg_q,       seg_d;
    logic [NUM_DIGITS-1:0] digit_en_q,  digit_en_d;

    logic                  any_low_s;
    logic                  lat_low_s;
    logic                  accept_s;
    logic [COL_W-1:0]      low_col_s;

    assign any_low_s = ~(&col_s_q);
    assign lat_low_s = ~col_s_q[lat_col_q];

    // Lowest-index closed column on the driven row.
    always_comb begin
        low_col_s = COL_W'(0);
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            low_col_s = col_s_q[c] ? low_col_s : COL_W'(c);
        end
    end

    // Scan / press-debounce / held / release-debounce next-state logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        lat_row_d   = lat_row_q;
        lat_col_d   = lat_col_q;
        deb_cnt_d   = deb_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        accept_s    = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DW_W'(ROW_DWELL - 1)) begin
                    dwell_d = DW_W'(0);
                    if (any_low_s) begin
                        lat_row_d = row_q;
                        lat_col_d = low_col_s;
                        deb_cnt_d = DEB_W'(0);
                        state_d   = ST_DEB_PRESS;
                    end else begin
                        row_d = next_row_f(row_q);
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (lat_low_s) begin
                    if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_code_f(lat_row_q, lat_col_q);
                        accept_s    = 1'b1;
                        deb_cnt_d   = DEB_W'(0);
                        state_d     = ST_HELD;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_d = DEB_W'(0);
                    row_d     = next_row_f(lat_row_q);
                    dwell_d   = DW_W'(0);
                    state_d   = ST_SCAN;
                end
            end
            ST_HELD: begin
                if (lat_low_s) begin
                    state_d = ST_HELD;
                end else begin
                    deb_cnt_d = DEB_W'(0);
                    state_d   = ST_DEB_REL;
                end
            end
            ST_DEB_REL: begin
                if (lat_low_s) begin
                    deb_cnt_d = DEB_W'(0);
                    state_d   = ST_HELD;
                end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt_d = DEB_W'(0);
                    row_d     = next_row_f(lat_row_q);
                    dwell_d   = DW_W'(0);
                    state_d   = ST_SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = ST_SCAN;
                row_d     = ROW_W'(0);
                dwell_d   = DW_W'(0);
                deb_cnt_d = DEB_W'(0);
            end
        endcase
        r_sel_d = ~(NUM_ROWS'(1) << row_d);
    end

    // Display buffer shift and digit multiplexer; seg and digit_en are
    // computed from the same next index so they update on the same edge.
    always_comb begin
        digit_d[0] = accept_s ? key_code_d : digit_q[0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            digit_d[i] = accept_s ? digit_q[i-1] : digit_q[i];
        end
`ifdef KEYPAD_BLANK_EN
        valid_d[0] = accept_s ? 1'b1 : valid_q[0];
        for (int i = 1; i < NUM_DIGITS; i++) begin
            valid_d[i] = accept_s ? valid_q[i-1] : valid_q[i];
        end
`endif
        mux_cnt_d = mux_cnt_q + MUX_DIV'(1);
        if (&mux_cnt_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? IDX_W'(0) : idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end
        digit_en_d = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_en_d[i] = (idx_d == IDX_W'(i));
        end
`ifdef KEYPAD_BLANK_EN
        seg_d = valid_d[idx_d] ? hex7_f(digit_d[idx_d]) : SEG_BLANK;
`else
        seg_d = hex7_f(digit_d[idx_d]);
`endif
    end

    // State and output registers; columns idle high through the synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta_q  <= {NUM_COLS{1'b1}};
            col_s_q     <= {NUM_COLS{1'b1}};
            state_q     <= ST_SCAN;
            row_q       <= ROW_W'(0);
            dwell_q     <= DW_W'(0);
            lat_row_q   <= ROW_W'(0);
            lat_col_q   <= COL_W'(0);
            deb_cnt_q   <= DEB_W'(0);
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 4'h0;
            end
`ifdef KEYPAD_BLANK_EN
            valid_q     <= {NUM_DIGITS{1'b0}};
`endif
            mux_cnt_q   <= MUX_DIV'(0);
            idx_q       <= IDX_W'(0);
            r_sel_q     <= ~NUM_ROWS'(1);
            seg_q       <= SEG_RESET;
            digit_en_q  <= NUM_DIGITS'(1);
        end else begin
            col_meta_q  <= col;
            col_s_q     <= col_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            lat_row_q   <= lat_row_d;
            lat_col_q   <= lat_col_d;
            deb_cnt_q   <= deb_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
`ifdef KEYPAD_BLANK_EN
            valid_q     <= valid_d;
`endif
            mux_cnt_q   <= mux_cnt_d;
            idx_q       <= idx_d;
            r_sel_q     <= r_sel_d;
            seg_q       <= seg_d;
            digit_en_q  <= digit_en_d;
        end
    end

    assign r_sel     = r_sel_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign seg       = seg_q;
    assign digit_en  = digit_en_q;

endmodule
